// File: rtl/fpm_pkg.sv
// fpm_pkg: shared channel state type and default parameters for flow_pulse_monitor
package fpm_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_H, MEAS_L} ch_state_t;
  localparam int CH_NUM_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int TIMEOUT_DEF = 25000;
  localparam int NCYC_DEF = 25;
  localparam int ERR_THD_DEF = 5;
  localparam int DUTY_SHIFT = 3;
endpackage

// File: rtl/flow_pulse_monitor_if.sv
// flow_pulse_monitor_if: meter pins and register-file side signals of flow_pulse_monitor
interface flow_pulse_monitor_if
  import fpm_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [CH_NUM-1:0] en_i;
  logic [CH_NUM-1:0] sig_i;
  logic [CNT_W-1:0] pdn_max_i;
  logic [CNT_W-1:0] pdn_min_i;
  logic err_clr_i;
  logic [CH_NUM*CNT_W-1:0] period_o;
  logic [CH_NUM*CNT_W-1:0] high_o;
  logic [CH_NUM-1:0] valid_o;
  logic [CH_NUM-1:0] stall_o;
  logic [CH_NUM-1:0] err_o;
  modport master (
    output en_i, sig_i, pdn_max_i, pdn_min_i, err_clr_i,
    input period_o, high_o, valid_o, stall_o, err_o
  );
  modport slave (
    input en_i, sig_i, pdn_max_i, pdn_min_i, err_clr_i,
    output period_o, high_o, valid_o, stall_o, err_o
  );
endinterface

// File: rtl/fpm_channel.sv
// fpm_channel: one meter channel - synchroniser, period FSM, limit check and error window
// FPM_DUTY_CHECK_EN adds high-time capture and the duty-window check
module fpm_channel
  import fpm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int NCYC = NCYC_DEF,
  parameter int ERR_THD = ERR_THD_DEF
) (
  input  logic clk_1us,
  input  logic rstn_i,
  input  logic en,
  input  logic sig,
  input  logic [CNT_W-1:0] pdn_max,
  input  logic [CNT_W-1:0] pdn_min,
  input  logic err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high,
  output logic valid,
  output logic stall,
  output logic err
);
  ch_state_t state;
  logic [2:0] sync;
  logic [CNT_W-1:0] cnt;
  logic [7:0] smp_cnt, bad_cnt, smp_nxt, bad_nxt;
  logic rise, fall, start, done, tmo, bad, duty_bad;
  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];
  assign start = rise && state == WAIT_RISE;
  assign done = rise && state == MEAS_L;
  // a real edge always wins over a timeout landing in the same cycle
  assign tmo = state != IDLE && !start && !done && cnt == CNT_W'(TIMEOUT);
  always_ff @(posedge clk_1us or negedge rstn_i)
    if (!rstn_i) sync <= '0;
    else sync <= {sync[1:0], sig};
  always_ff @(posedge clk_1us or negedge rstn_i)
    if (!rstn_i) begin
      state <= IDLE;
      cnt <= '0;
      period <= '0;
      valid <= 1'b0;
      stall <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      cnt <= '0;
      period <= '0;
      valid <= 1'b0;
      stall <= 1'b0;
    end else begin
      valid <= done | tmo;
      cnt <= (start || done) ? CNT_W'(1) : (tmo || state == IDLE) ? '0 : cnt + CNT_W'(1);
      if (done) begin
        period <= cnt;
        stall <= 1'b0;
      end else if (tmo) begin
        period <= '0;
        stall <= 1'b1;
      end
      if (state == IDLE || tmo) state <= WAIT_RISE;
      else if (start || done) state <= MEAS_H;
      else if (state == MEAS_H && fall) state <= MEAS_L;
    end
`ifdef FPM_DUTY_CHECK_EN
  logic [CNT_W-1:0] hcnt, eighth;
  always_ff @(posedge clk_1us or negedge rstn_i)
    if (!rstn_i) begin
      hcnt <= '0;
      high <= '0;
    end else if (!en) begin
      hcnt <= '0;
      high <= '0;
    end else begin
      if (state == MEAS_H && fall) hcnt <= cnt;
      if (done) high <= hcnt;
      else if (tmo) high <= '0;
    end
  assign eighth = period >> DUTY_SHIFT;
  assign duty_bad = high < eighth || high > period - eighth;
`else
  assign high = '0;
  assign duty_bad = 1'b0;
`endif
  // window runs one cycle behind the sample, off the registered outputs
  assign bad = stall || period > pdn_max || period < pdn_min || duty_bad;
  assign smp_nxt = smp_cnt + 8'd1;
  assign bad_nxt = bad_cnt + {7'd0, bad};
  always_ff @(posedge clk_1us or negedge rstn_i)
    if (!rstn_i) begin
      smp_cnt <= '0;
      bad_cnt <= '0;
      err <= 1'b0;
    end else if (!en || err_clr) begin
      smp_cnt <= '0;
      bad_cnt <= '0;
      err <= 1'b0;
    end else if (valid) begin
      err <= err || bad_nxt > 8'(ERR_THD);
      smp_cnt <= smp_nxt == 8'(NCYC) ? '0 : smp_nxt;
      bad_cnt <= smp_nxt == 8'(NCYC) ? '0 : bad_nxt;
    end
endmodule

// File: rtl/flow_pulse_monitor.sv
// flow_pulse_monitor: CH_NUM independent flow-meter channels with packed result buses
// FPM_DUTY_CHECK_EN enables high-time capture and duty checking in every channel
module flow_pulse_monitor
  import fpm_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int NCYC = NCYC_DEF,
  parameter int ERR_THD = ERR_THD_DEF
) (
  input logic clk_1us,
  input logic rstn_i,
  flow_pulse_monitor_if.slave bus
);
  logic [CNT_W-1:0] period [CH_NUM];
  logic [CNT_W-1:0] high [CH_NUM];
  logic [CH_NUM-1:0] valid, stall, err;
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    fpm_channel #(
      .CNT_W(CNT_W),
      .TIMEOUT(TIMEOUT),
      .NCYC(NCYC),
      .ERR_THD(ERR_THD)
    ) u_ch (
      .clk_1us(clk_1us),
      .rstn_i(rstn_i),
      .en(bus.en_i[i]),
      .sig(bus.sig_i[i]),
      .pdn_max(bus.pdn_max_i),
      .pdn_min(bus.pdn_min_i),
      .err_clr(bus.err_clr_i),
      .period(period[i]),
      .high(high[i]),
      .valid(valid[i]),
      .stall(stall[i]),
      .err(err[i])
    );
    assign bus.period_o[i*CNT_W +: CNT_W] = period[i];
    assign bus.high_o[i*CNT_W +: CNT_W] = high[i];
  end
  assign bus.valid_o = valid;
  assign bus.stall_o = stall;
  assign bus.err_o = err;
endmodule

// File: doc/flow_pulse_monitor.md
# flow_pulse_monitor

Multi-channel successor to the single-channel water-meter detector. It measures period and high time of up to CH_NUM independent flow-sensor pulse trains in 1 µs ticks. It qualifies each sample against programmable period limits and a duty window, and raises a per-channel error after too many bad samples in a fixed window. It sits between the meter input pins and the register file, one instance serving all meter channels.

## Interface
- CH_NUM, 4: number of independent channels (1..8)
- CNT_W, 16: period/high counter width in bits
- TIMEOUT, 25000: ticks without a rising edge before a stall sample is generated (< 2^CNT_W)
- NCYC, 25: samples per evaluation window (1..255)
- ERR_THD, 5: error asserted when bad-sample count > ERR_THD

- clk_1us  in  1  1 µs tick clock
- rstn_i  in  1  reset, asynchronous, active-low
- en_i  in  CH_NUM  per-channel enable
- sig_i  in  CH_NUM  asynchronous flow pulse inputs
- pdn_max_i  in  CNT_W  period upper limit (shared)
- pdn_min_i  in  CNT_W  period lower limit (shared)
- err_clr_i  in  1  one-cycle pulse, clears all err_o and windows
- period_o  out  CH_NUM*CNT_W  last period per channel, ch0 in LSBs
- high_o  out  CH_NUM*CNT_W  last high time per channel
- valid_o  out  CH_NUM  one-cycle pulse per new sample
- stall_o  out  CH_NUM  channel timed out, no pulses
- err_o  out  CH_NUM  sticky error flag

## Operation
- Per channel: 2-flop synchroniser, then edge detect on the synchronised pair.
- States per channel:
  - IDLE → WAIT_RISE when en_i=1.
  - WAIT_RISE → MEAS_H on a rising edge.
  - MEAS_H → MEAS_L on a falling edge.
  - MEAS_L → MEAS_H on a rising edge, closing a sample.
  - Any state → IDLE when en_i=0.
- The first partial period after enable is discarded: counting starts at the first rising edge.
- Counter cnt is set to 1 in the cycle after a rising edge and increments each tick. At a falling edge, hcnt <= cnt. At a rising edge, period_o <= cnt and high_o <= hcnt, so period = P for rising edges P ticks apart.
- Timeout: if cnt (or the idle counter in WAIT_RISE) reaches TIMEOUT, emit a stall sample:
  - period_o=0, high_o=0, valid_o pulse, stall_o=1.
  - State → WAIT_RISE.
  - stall_o clears on the next normal sample.
- A sample is bad if any of the following holds:
  - it is a stall sample;
  - period > pdn_max_i;
  - period < pdn_min_i;
  - (duty check enabled) high < period>>3 or high > period−(period>>3).
- Window: each sample increments smp_cnt, and bad samples increment bad_cnt. When bad_cnt > ERR_THD, err_o <= 1 immediately (sticky). When smp_cnt reaches NCYC, both counters clear and the window restarts. err_o is never cleared by a good window.
- err_clr_i clears err_o, smp_cnt and bad_cnt on all channels. It has priority over a simultaneous bad sample; that sample is dropped from the new window.
- en_i=0 on a channel: synchronously clears its counters, state, period_o, high_o, stall_o and err_o.
- Arithmetic is unsigned CNT_W throughout; counters never wrap because the timeout fires first.

## Timing
- Reset values: all outputs 0; all channels in IDLE; synchronisers 0.
- Latency: valid_o, period_o and high_o update on the 3rd clk_1us edge after sig_i rises (2 sync + 1 edge register).
- err_o updates 1 cycle after the valid_o that caused it.
- Minimum resolvable high or low time: 2 ticks. Narrower pulses may be lost.
- Channels are fully independent. Simultaneous samples on several channels are all processed in the same cycle.
- Reset mid-measurement: everything returns to reset values; the next enable starts in WAIT_RISE.

## Configuration
- FPM_DUTY_CHECK_EN defined: the duty window is evaluated as part of the bad-sample test, and high_o is driven.
- FPM_DUTY_CHECK_EN undefined: only period limits and timeout count as bad; high_o is tied to 0; hcnt logic is removed.

## Structure
- Package fpm_pkg:
  - channel state enum (IDLE, WAIT_RISE, MEAS_H, MEAS_L);
  - default parameter constants;
  - duty-shift constant (3).
- Sub-module fpm_channel: synchroniser, FSM, counters, limit/duty check and error window for one channel.
- Top level: generate loop over CH_NUM, plus output bus packing.

## Test plan
- Square wave on ch0, 300 µs high / 700 µs low, limits 500..2000 → period_o=1000, high_o=300, valid_o every 1000 cycles, err_o=0.
- ch1 with 10 µs high / 990 µs low and FPM_DUTY_CHECK_EN defined → every sample bad; err_o rises 1 cycle after the 6th valid_o. With the macro undefined, err_o stays 0.
- ch2 held low after 3 good periods → stall sample after 25000 ticks (period_o=0, stall_o=1); stall_o clears on the next period.
- Enable a channel mid-high-pulse → first valid_o only after one full rise-to-rise period; no partial sample.
- err_clr_i in the same cycle as the 6th bad sample → err_o stays 0 and bad_cnt=0.
- rstn_i asserted mid-measurement, then a 4-channel mix of 1000/2000/4000/25 µs periods → all outputs 0 during reset; afterwards each channel reports its own period independently.
